// File: rtl/fifo_downsize.sv
// Width-converting FIFO: accepts IN_W-bit beats and returns them as RATIO OUT_W-bit words,
// first-word fall-through, with sticky overflow/underflow flags.
module fifo_downsize #(
    parameter int unsigned IN_W      = 128,
    parameter int unsigned OUT_W     = 32,
    parameter int unsigned DEPTH     = 64,
    parameter bit          MSW_FIRST = 1'b1,
    parameter int unsigned AF_LEVEL  = DEPTH - 2 * (IN_W / OUT_W)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [IN_W-1:0]          wr_data_i,
    input  logic                     rd_en_i,
    output logic [OUT_W-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic                     almost_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned CW    = PW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [OUT_W-1:0] wr_words [RATIO];
    logic [CW-1:0]    free_words;
    logic             wr_acc, rd_acc;

    // wr_words[0] is the word read first out of each beat.
    for (genvar g = 0; g < RATIO; g++) begin : g_split
        localparam int unsigned Slot = MSW_FIRST ? (RATIO - 1 - g) : g;
        assign wr_words[g] = wr_data_i[Slot*OUT_W +: OUT_W];
    end

    assign free_words    = CW'(DEPTH) - count_q;
    assign full_o        = free_words < CW'(RATIO);
    assign empty_o       = (count_q == '0);
    assign almost_full_o = 32'(count_q) >= AF_LEVEL;
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign underflow_o   = underflow_q;
    assign rd_data_o     = mem_q[rd_ptr_q];

    assign wr_acc = wr_en_i && !full_o && !flush_i;
    assign rd_acc = rd_en_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q || (wr_en_i && full_o);
        underflow_d = underflow_q || (rd_en_i && empty_o);
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(RATIO);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + (wr_acc ? CW'(RATIO) : CW'(0)) - (rd_acc ? CW'(1) : CW'(0));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a beat never straddles the wrap since DEPTH % RATIO == 0.
    always_ff @(posedge clk) begin
        if (resetn && wr_acc) begin
            for (int unsigned i = 0; i < RATIO; i++) begin
                mem_q[wr_ptr_q + PW'(i)] <= wr_words[i];
            end
        end
    end

endmodule

// File: tb/tb_fifo_downsize.sv
// Scoreboard bench for fifo_downsize: default instance plus an MSW_FIRST=0 instance.
module tb_fifo_downsize;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic [127:0]  wr_data = '0;
    logic          rd_en = 1'b0;
    logic [31:0]   rd_data;
    logic          empty, full, almost_full, overflow, underflow;
    logic [6:0]    count;

    logic          wr_en1 = 1'b0;
    logic [127:0]  wr_data1 = '0;
    logic          rd_en1 = 1'b0;
    logic [31:0]   rd_data1;
    logic          empty1, full1, almost_full1, overflow1, underflow1;
    logic [6:0]    count1;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;
    logic [31:0] sb_q [$];

    localparam logic [127:0] Beat = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    always #5 clk = ~clk;

    fifo_downsize dut (
        .clk          (clk),
        .resetn       (resetn),
        .flush_i      (flush),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .rd_en_i      (rd_en),
        .rd_data_o    (rd_data),
        .empty_o      (empty),
        .full_o       (full),
        .almost_full_o(almost_full),
        .count_o      (count),
        .overflow_o   (overflow),
        .underflow_o  (underflow)
    );

    fifo_downsize #(.MSW_FIRST(1'b0)) dut_lsw (
        .clk          (clk),
        .resetn       (resetn),
        .flush_i      (1'b0),
        .wr_en_i      (wr_en1),
        .wr_data_i    (wr_data1),
        .rd_en_i      (rd_en1),
        .rd_data_o    (rd_data1),
        .empty_o      (empty1),
        .full_o       (full1),
        .almost_full_o(almost_full1),
        .count_o      (count1),
        .overflow_o   (overflow1),
        .underflow_o  (underflow1)
    );

    // One cycle on the default instance, called just after a falling edge. Keeps the model
    // and scoreboard in step and hands back the observed/expected head word for a pop.
    task automatic step(input bit we, input logic [127:0] d, input bit re, input bit fl,
                        output logic [31:0] got, output logic [31:0] exp, output bit popped);
        bit w_ok, r_ok;
        w_ok   = we && !fl && ((64 - model_cnt) >= 4);
        r_ok   = re && !fl && (model_cnt != 0);
        flush  = fl;
        wr_en  = we;
        wr_data = d;
        rd_en  = re;
        got    = rd_data;
        exp    = '0;
        popped = 1'b0;
        if (r_ok) begin
            exp    = sb_q.pop_front();
            popped = 1'b1;
        end
        if (w_ok) begin
            for (int k = 0; k < 4; k++) sb_q.push_back(d[127 - 32*k -: 32]);
        end
        if (fl) begin
            sb_q.delete();
            model_cnt = 0;
        end else begin
            model_cnt = model_cnt + (w_ok ? 4 : 0) - (r_ok ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        sb_q.delete();
        model_cnt = 0;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b want=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b want=0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got=%b want=0", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_udf got=%b want=0", underflow); end
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL reset_empty_lsw got=%b want=1", empty1); end
    endtask

    task automatic test_msw_order();
        logic [31:0] got, exp;
        bit popped;
        logic [31:0] lit [4];
        lit = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
        step(1'b1, Beat, 1'b0, 1'b0, got, exp, popped);
        checks++; if (count !== 7'd4) begin errors++; $display("FAIL msw_count_wr got=%0d want=4", count); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL msw_empty_wr got=%b want=0", empty); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1, 1'b0, got, exp, popped);
            checks++;
            if (!popped || got !== exp || got !== lit[i]) begin
                errors++; $display("FAIL msw_word%0d got=%h want=%h", i, got, lit[i]);
            end
            checks++;
            if (count !== 7'(3 - i)) begin
                errors++; $display("FAIL msw_count%0d got=%0d want=%0d", i, count, 3 - i);
            end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL msw_empty_end got=%b want=1", empty); end
    endtask

    task automatic test_lsw_first();
        logic [31:0] lit [4];
        lit = '{32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
        wr_en1 = 1'b1;
        wr_data1 = Beat;
        @(posedge clk);
        @(negedge clk);
        wr_en1 = 1'b0;
        checks++; if (count1 !== 7'd4) begin errors++; $display("FAIL lsw_count got=%0d want=4", count1); end
        for (int i = 0; i < 4; i++) begin
            rd_en1 = 1'b1;
            checks++;
            if (rd_data1 !== lit[i]) begin
                errors++; $display("FAIL lsw_word%0d got=%h want=%h", i, rd_data1, lit[i]);
            end
            @(posedge clk);
            @(negedge clk);
            rd_en1 = 1'b0;
        end
        checks++; if (empty1 !== 1'b1) begin errors++; $display("FAIL lsw_empty got=%b want=1", empty1); end
    endtask

    task automatic test_full_overflow();
        logic [31:0] got, exp;
        bit popped;
        int bad;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, got, exp, popped);
            checks++;
            if (almost_full !== (model_cnt >= 56)) begin
                errors++; $display("FAIL fill_af%0d got=%b want=%b", i, almost_full, model_cnt >= 56);
            end
        end
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL fill_count got=%0d want=64", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got=%b want=1", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf got=%b want=0", overflow); end
        step(1'b1, {4{32'hDEADBEEF}}, 1'b0, 1'b0, got, exp, popped);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
        checks++; if (count !== 7'd64) begin errors++; $display("FAIL ovf_count got=%0d want=64", count); end
        step(1'b0, '0, 1'b1, 1'b0, got, exp, popped);
        checks++; if (!popped || got !== exp) begin errors++; $display("FAIL full_rd1 got=%h want=%h", got, exp); end
        checks++; if (count !== 7'd63) begin errors++; $display("FAIL full_count63 got=%0d want=63", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_at63 got=%b want=1", full); end
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, got, exp, popped);
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL full_at60 got=%b want=0", full); end
        bad = 0;
        while (model_cnt > 0) begin
            step(1'b0, '0, 1'b1, 1'b0, got, exp, popped);
            if (got !== exp) begin
                bad++; $display("FAIL drain_word got=%h want=%h", got, exp);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got=%b want=1", empty); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] got, exp;
        bit popped;
        step(1'b1, 128'h11111111_22222222_33333333_44444444, 1'b0, 1'b0, got, exp, popped);
        step(1'b1, 128'h55555555_66666666_77777777_88888888, 1'b0, 1'b0, got, exp, popped);
        checks++; if (count !== 7'd8) begin errors++; $display("FAIL simul_pre got=%0d want=8", count); end
        step(1'b1, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 1'b1, 1'b0, got, exp, popped);
        checks++;
        if (!popped || got !== exp || got !== 32'h11111111) begin
            errors++; $display("FAIL simul_head got=%h want=%h", got, 32'h11111111);
        end
        checks++; if (count !== 7'd11) begin errors++; $display("FAIL simul_count got=%0d want=11", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, exp;
        bit popped, we;
        int reads, bad, cbad;
        reads = 0; bad = 0; cbad = 0;
        // Reads are the bottleneck, so 3+ laps of 64 words means well over 192 pops.
        while (reads < 3 * 64 + 32 || model_cnt > 0) begin
            we = (reads < 3 * 64 + 32) && (model_cnt < 40) && ($urandom_range(0, 3) != 0);
            step(we, {$urandom, $urandom, $urandom, $urandom}, model_cnt != 0, 1'b0,
                 got, exp, popped);
            if (popped) begin
                reads++;
                if (got !== exp) begin
                    bad++; $display("FAIL wrap_word%0d got=%h want=%h", reads, got, exp);
                end
            end
            if (count !== 7'(model_cnt)) begin
                cbad++; $display("FAIL wrap_count got=%0d want=%0d", count, model_cnt);
            end
        end
        checks++; if (bad != 0) errors++;
        checks++; if (cbad != 0) errors++;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b want=1", empty); end
    endtask

    task automatic test_underflow_flush();
        logic [31:0] got, exp;
        bit popped;
        step(1'b0, '0, 1'b1, 1'b0, got, exp, popped);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL udf_set got=%b want=1", underflow); end
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL udf_count got=%0d want=0", count); end
        for (int i = 0; i < 5; i++) begin
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, got, exp, popped);
        end
        checks++; if (count !== 7'd20) begin errors++; $display("FAIL flush_pre got=%0d want=20", count); end
        step(1'b1, {4{32'hBAD0BAD0}}, 1'b1, 1'b1, got, exp, popped);
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got=%b want=1", empty); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL flush_udf got=%b want=1", underflow); end
        step(1'b1, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 1'b0, 1'b0, got, exp, popped);
        step(1'b0, '0, 1'b1, 1'b0, got, exp, popped);
        checks++;
        if (got !== 32'hA0A0A0A0 || got !== exp) begin
            errors++; $display("FAIL flush_head got=%h want=%h", got, 32'hA0A0A0A0);
        end
        checks++; if (count !== 7'd3) begin errors++; $display("FAIL flush_post got=%0d want=3", count); end
    endtask

    task automatic test_reset_again();
        resetn = 1'b0;
        flush  = 1'b1;
        wr_en  = 1'b1;
        rd_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        resetn = 1'b1;
        sb_q.delete();
        model_cnt = 0;
        checks++; if (count !== 7'd0) begin errors++; $display("FAIL rst2_count got=%0d want=0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst2_empty got=%b want=1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL rst2_full got=%b want=0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst2_af got=%b want=0", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst2_ovf got=%b want=0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL rst2_udf got=%b want=0", underflow); end
    endtask

    initial begin
        test_reset();
        test_msw_order();
        test_lsw_first();
        test_full_overflow();
        test_simultaneous();
        test_back_to_back();
        test_underflow_flush();
        test_reset_again();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_downsize.md
FIFO_DOWNSIZE -- requirements
Module: fifo_downsize

Interface
REQ-001 Parameter IN_W, default 128, write-port data width in bits.
REQ-002 Parameter OUT_W, default 32, read-port data width in bits; IN_W SHALL be an integer multiple of OUT_W, with RATIO = IN_W/OUT_W.
REQ-003 Parameter DEPTH, default 64, storage in OUT_W words; a power of two and a multiple of RATIO.
REQ-004 Parameter MSW_FIRST, default 1, word order: 1 = wr_data[IN_W-1 -: OUT_W] is read first; 0 = wr_data[OUT_W-1:0] is read first.
REQ-005 Parameter AF_LEVEL, default DEPTH-2*RATIO, almost_full threshold in words.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 resetn  input  1  reset, synchronous, active-low.
REQ-008 flush  input  1  synchronous clear of FIFO contents.
REQ-009 wr_en  input  1  write request for one IN_W beat.
REQ-010 wr_data  input  IN_W  write beat.
REQ-011 rd_en  input  1  pop one OUT_W word.
REQ-012 rd_data  output  OUT_W  head word (first-word fall-through).
REQ-013 empty  output  1  count == 0.
REQ-014 full  output  1  free words (DEPTH-count) < RATIO.
REQ-015 almost_full  output  1  count >= AF_LEVEL.
REQ-016 count  output  clog2(DEPTH)+1  words stored.
REQ-017 overflow  output  1  sticky: write attempted while full.
REQ-018 underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 A write SHALL be accepted when wr_en=1, full=0 and flush=0; it stores RATIO words at wr_ptr..wr_ptr+RATIO-1 (mod DEPTH) in the order set by MSW_FIRST.
REQ-020 A read SHALL be accepted when rd_en=1, empty=0 and flush=0; rd_ptr advances by 1 mod DEPTH.
REQ-021 rd_data SHALL equal the word at rd_ptr combinationally; its value is don't-care while empty=1.
REQ-022 Pointers SHALL be clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; a RATIO-word write SHALL never straddle the wrap, guaranteed by DEPTH % RATIO == 0.
REQ-023 count SHALL update in the same edge as the accepted operations: count_next = count + RATIO*(write accepted) - (read accepted), including simultaneous write and read.
REQ-024 Simultaneous write and read SHALL both be accepted when individually legal; the read SHALL return the pre-existing head word.
REQ-025 A write to an empty FIFO SHALL make its first word visible on rd_data and drop empty in the cycle after the accepting edge (latency 1).
REQ-026 A rejected write (wr_en=1, full=1) SHALL leave memory, pointers and count unchanged and set overflow to 1.
REQ-027 A rejected read (rd_en=1, empty=1) SHALL leave state unchanged and set underflow to 1.
REQ-028 overflow and underflow SHALL remain set until reset; flush SHALL NOT clear them.
REQ-029 flush=1 SHALL set wr_ptr, rd_ptr and count to 0 and take priority over wr_en and rd_en in the same cycle; memory contents are not cleared.
REQ-030 full, empty and almost_full SHALL be combinational decodes of the registered count.

Reset
REQ-031 With resetn=0 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0; therefore empty=1, full=0, almost_full=0.
REQ-032 Reset SHALL take priority over flush, wr_en and rd_en, and SHALL abandon any partially read beat.
REQ-033 Memory SHALL NOT require reset.

Verification
REQ-034 Defaults, write 0x00112233_44556677_8899AABB_CCDDEEFF, then 4 reads -> rd_data = 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; count steps 4,3,2,1,0; empty=1 after the last read.
REQ-035 MSW_FIRST=0, same beat -> reads return 0xCCDDEEFF first and 0x00112233 last.
REQ-036 16 writes with no reads -> count=64, full=1; a 17th write sets overflow=1 with count=64; after 1 read, count=63 and full=1 (since 1 < 4 free words); after 4 reads, full=0.
REQ-037 Count=8 with write and read in the same cycle -> count=11; head word is the oldest word; continuous traffic across the pointer wrap preserves data order over 3 full laps.
REQ-038 rd_en while empty -> underflow=1 and count=0; then flush with wr_en=1 at count=20 -> count=0 and the write is dropped; underflow is still 1; resetn=0 -> all outputs return to the REQ-031 values.
